// File: rtl/aes_wb_ctrl.sv
// aes_wb_ctrl: Wishbone B3 slave front-end for AES cipher cores.
// Key/data register files, start/done sequencing, latency counter.
module aes_wb_ctrl #(
   parameter int BLOCK_WORDS = 4,
   parameter int KEY_WORDS   = 4,
   parameter int CNT_W       = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [7:0]                wb_adr_i,
   input  logic [31:0]               wb_dat_i,
   output logic [31:0]               wb_dat_o,
   input  logic [3:0]                wb_sel_i,
   input  logic                      wb_we_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   output logic                      wb_ack_o,
   output logic                      irq_o,
   output logic                      core_start_o,
   output logic                      core_decrypt_o,
   output logic [32*KEY_WORDS-1:0]   core_key_o,
   output logic [32*BLOCK_WORDS-1:0] core_data_o,
   input  logic                      core_done_i,
   input  logic [32*BLOCK_WORDS-1:0] core_data_i
);

   localparam int DW = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT} state_t;

   state_t             r_state;
   logic               r_ack;
   logic [31:0]        r_rdat;
   logic [31:0]        r_din [BLOCK_WORDS];
   logic [31:0]        r_key [KEY_WORDS];
   logic [DW-1:0]      r_dout;
   logic [DW-1:0]      r_capt;
   logic [DW-1:0]      r_core_data;
   logic               r_core_dec;
   logic               r_start;
   logic               r_dec;
   logic               r_auto;
   logic               r_irq_en;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_cycles;

   logic               w_acc;
   logic               w_wr;
   logic [1:0]         w_rg;
   logic [3:0]         w_idx;
   logic               w_ctrl_wr;
   logic               w_stat_wr;
   logic               w_auto_req;
   logic               w_start_req;
   logic               w_dec_new;
   logic               w_clr_done;
   logic               w_clr_err;
   logic [31:0]        w_rdat;
   logic [31:0]        w_din_new [BLOCK_WORDS];
   logic [DW-1:0]      w_din_flat;
   logic               w_unused;

   function automatic logic [31:0] f_merge(input logic [31:0] o,
                                           input logic [31:0] d,
                                           input logic [3:0]  s);
      for (int b = 0; b < 4; b++)
         if (s[b]) o[8*b +: 8] = d[8*b +: 8];
      return o;
   endfunction

   assign w_unused    = &{1'b0, wb_adr_i[1:0]};
   assign w_acc       = wb_cyc_i & wb_stb_i;
   assign w_wr        = w_acc & wb_we_i & r_ack;
   assign w_rg        = wb_adr_i[7:6];
   assign w_idx       = wb_adr_i[5:2];
   assign w_ctrl_wr   = w_wr && (w_rg == 2'd3) && (w_idx == 4'd0);
   assign w_stat_wr   = w_wr && (w_rg == 2'd3) && (w_idx == 4'd1);
   assign w_auto_req  = w_wr && r_auto && (w_rg == 2'd0) &&
                        (int'(w_idx) == BLOCK_WORDS - 1);
   assign w_start_req = (w_ctrl_wr & wb_sel_i[0] & wb_dat_i[0]) | w_auto_req;
   assign w_dec_new   = (w_ctrl_wr & wb_sel_i[0]) ? wb_dat_i[1] : r_dec;
   assign w_clr_done  = w_stat_wr & wb_sel_i[0] & wb_dat_i[1];
   assign w_clr_err   = w_stat_wr & wb_sel_i[0] & wb_dat_i[2];

   assign wb_ack_o       = r_ack;
   assign wb_dat_o       = r_rdat;
   assign irq_o          = r_done & r_irq_en;
   assign core_start_o   = r_start;
   assign core_decrypt_o = r_core_dec;
   assign core_data_o    = r_core_data;

   // Next DIN contents, so a start on the last-word write sees the new word
   always_comb begin
      w_din_new = r_din;
      for (int i = 0; i < BLOCK_WORDS; i++)
         if (w_wr && (w_rg == 2'd0) && (int'(w_idx) == i))
            w_din_new[i] = f_merge(r_din[i], wb_dat_i, wb_sel_i);
   end

   // Flatten block and key word arrays onto the core buses
   always_comb begin
      w_din_flat = '0;
      core_key_o = '0;
      for (int i = 0; i < BLOCK_WORDS; i++)
         w_din_flat[32*i +: 32] = w_din_new[i];
      for (int i = 0; i < KEY_WORDS; i++)
         core_key_o[32*i +: 32] = r_key[i];
   end

   // Read-data mux; out-of-range words and unmapped slots return 0
   always_comb begin
      w_rdat = '0;
      unique case (w_rg)
         2'd0:
            for (int i = 0; i < BLOCK_WORDS; i++)
               if (int'(w_idx) == i) w_rdat = r_din[i];
         2'd1:
            for (int i = 0; i < BLOCK_WORDS; i++)
               if (int'(w_idx) == i) w_rdat = r_dout[32*i +: 32];
         2'd2:
            for (int i = 0; i < KEY_WORDS; i++)
               if (int'(w_idx) == i) w_rdat = r_key[i];
         2'd3:
            case (w_idx)
               4'd0:    w_rdat = {28'd0, r_irq_en, r_auto, r_dec, 1'b0};
               4'd1:    w_rdat = {29'd0, r_err, r_done, r_busy};
               4'd2:    w_rdat = 32'(r_cycles);
               default: w_rdat = '0;
            endcase
         default: w_rdat = '0;
      endcase
   end

   // Registered single-cycle ack with read data captured alongside
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack  <= 1'b0;
         r_rdat <= '0;
      end else begin
         r_ack <= w_acc & ~r_ack;
         if (w_acc & ~r_ack) r_rdat <= w_rdat;
      end
   end

   // Software-visible DIN, KEY and CTRL registers, written on the ack edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < BLOCK_WORDS; i++) r_din[i] <= '0;
         for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= '0;
         r_dec    <= 1'b0;
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         r_din <= w_din_new;
         for (int i = 0; i < KEY_WORDS; i++)
            if (w_wr && (w_rg == 2'd2) && (int'(w_idx) == i))
               r_key[i] <= f_merge(r_key[i], wb_dat_i, wb_sel_i);
         if (w_ctrl_wr && wb_sel_i[0])
            {r_irq_en, r_auto, r_dec} <= wb_dat_i[3:1];
      end
   end

   // Operation sequencer: snapshot, start pulse, latency count, capture
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_start     <= 1'b0;
         r_core_dec  <= 1'b0;
         r_core_data <= '0;
         r_capt      <= '0;
         r_dout      <= '0;
         r_cnt       <= '0;
         r_cycles    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            S_IDLE:
               if (w_start_req) begin
                  r_state     <= S_RUN;
                  r_start     <= 1'b1;
                  r_core_data <= w_din_flat;
                  r_core_dec  <= w_dec_new;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
               end
            S_RUN:
               if (core_done_i) begin
                  r_capt  <= core_data_i;
                  r_state <= S_CAPT;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            S_CAPT: begin
               r_dout   <= r_capt;
               r_cycles <= r_cnt;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (r_state == S_CAPT) r_done <= 1'b1;
         else if (w_clr_done)   r_done <= 1'b0;
         if (w_start_req && (r_state != S_IDLE)) r_err <= 1'b1;
         else if (w_clr_err)                     r_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_wb_ctrl.sv
// tb_aes_wb_ctrl: directed checks of the AES Wishbone front-end.
// A second instance with a 4-bit counter covers saturation.
module tb_aes_wb_ctrl;

   localparam logic [127:0] PT = {32'hccddeeff, 32'h8899aabb,
                                  32'h44556677, 32'h00112233};
   localparam logic [127:0] KY = {32'h0c0d0e0f, 32'h08090a0b,
                                  32'h04050607, 32'h00010203};
   localparam logic [127:0] CT = {32'h70b4c55a, 32'hd8cdb780,
                                  32'h6a7b0430, 32'h69c4e0d8};

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   adr;
   logic [31:0]  dat_i;
   logic [3:0]   sel;
   logic         we, cyc, stb;
   logic [31:0]  dat_o, dat_o2;
   logic         ack, ack2, irq, irq2, st, st2, dec, dec2;
   logic [127:0] key, key2, cdo, cdo2;
   logic         done_i;
   logic [127:0] cdi;
   logic [127:0] m_out;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   bit model_en = 1'b1;
   int model_lat = 10;

   always #5 clk = ~clk;

   aes_wb_ctrl u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
      .wb_dat_o(dat_o), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
      .wb_stb_i(stb), .wb_ack_o(ack), .irq_o(irq), .core_start_o(st),
      .core_decrypt_o(dec), .core_key_o(key), .core_data_o(cdo),
      .core_done_i(done_i), .core_data_i(cdi)
   );

   aes_wb_ctrl #(.CNT_W(4)) u_sat (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
      .wb_dat_o(dat_o2), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
      .wb_stb_i(stb), .wb_ack_o(ack2), .irq_o(irq2), .core_start_o(st2),
      .core_decrypt_o(dec2), .core_key_o(key2), .core_data_o(cdo2),
      .core_done_i(done_i), .core_data_i(cdi)
   );

   // Count start pulses seen by the main instance
   initial forever begin
      @(posedge clk);
      #3;
      if (st) start_cnt++;
   end

   // Core model: fixed latency; FIPS-197 vector answer, else data^key
   initial begin
      done_i = 1'b0;
      cdi = '0;
      forever begin
         @(posedge clk);
         #1;
         if (model_en && st && !rst) begin
            m_out = (cdo == PT && key == KY && !dec) ? CT : (cdo ^ key);
            repeat (model_lat) @(posedge clk);
            #1;
            done_i = 1'b1;
            cdi = m_out;
            @(posedge clk);
            #1;
            done_i = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output logic [31:0] r2);
      int n;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack && n < 8);
      if (!ack) begin
         n_cmp++;
         n_err++;
         $display("FAIL ack_timeout: adr %h got no ack want ack", a);
      end
      r = dat_o;
      r2 = dat_o2;
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s = 4'hF);
      logic [31:0] r, r2;
      bus(1'b1, a, d, s, r, r2);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] r);
      logic [31:0] r2;
      bus(1'b0, a, 32'h0, 4'h0, r, r2);
   endtask

   task automatic wait_idle();
      logic [31:0] r;
      int k;
      k = 0;
      do begin
         rd(8'hC4, r);
         k++;
      end while (r[0] && k < 40);
      if (r[0]) begin
         n_cmp++;
         n_err++;
         $display("FAIL busy_timeout: got busy=1 want 0");
      end
   endtask

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] e;
      string       nm;
   } vec_t;

   vec_t tv[$];

   initial begin
      logic [31:0] r, r2;
      rst = 1'b1; adr = '0; dat_i = '0; sel = '0;
      we = 1'b0; cyc = 1'b0; stb = 1'b0;

      tv.push_back('{0, 8'h00, 0, 0, 32'h0, "rst_din0"});
      tv.push_back('{0, 8'h0C, 0, 0, 32'h0, "rst_din3"});
      tv.push_back('{0, 8'h40, 0, 0, 32'h0, "rst_dout0"});
      tv.push_back('{0, 8'h4C, 0, 0, 32'h0, "rst_dout3"});
      tv.push_back('{0, 8'h80, 0, 0, 32'h0, "rst_key0"});
      tv.push_back('{0, 8'h8C, 0, 0, 32'h0, "rst_key3"});
      tv.push_back('{0, 8'hC0, 0, 0, 32'h0, "rst_ctrl"});
      tv.push_back('{0, 8'hC4, 0, 0, 32'h0, "rst_status"});
      tv.push_back('{0, 8'hC8, 0, 0, 32'h0, "rst_cycles"});
      tv.push_back('{1, 8'hC0, 32'hF, 4'h0, 0, ""});
      tv.push_back('{0, 8'hC0, 0, 0, 32'h0, "ctrl_sel0"});
      tv.push_back('{0, 8'hC4, 0, 0, 32'h0, "status_sel0"});
      tv.push_back('{1, 8'h80, 32'hAABBCCDD, 4'hF, 0, ""});
      tv.push_back('{1, 8'h80, 32'h11223344, 4'h5, 0, ""});
      tv.push_back('{0, 8'h80, 0, 0, 32'hAA22CC44, "key_bytelane"});
      tv.push_back('{1, 8'h04, 32'h12345678, 4'hF, 0, ""});
      tv.push_back('{0, 8'h04, 0, 0, 32'h12345678, "din1_rw"});
      tv.push_back('{1, 8'h10, 32'hDEADBEEF, 4'hF, 0, ""});
      tv.push_back('{0, 8'h10, 0, 0, 32'h0, "din4_unmapped"});
      tv.push_back('{1, 8'h90, 32'hDEADBEEF, 4'hF, 0, ""});
      tv.push_back('{0, 8'h90, 0, 0, 32'h0, "key4_unmapped"});
      tv.push_back('{1, 8'h40, 32'hFFFFFFFF, 4'hF, 0, ""});
      tv.push_back('{0, 8'h40, 0, 0, 32'h0, "dout_ro"});
      tv.push_back('{0, 8'hD0, 0, 0, 32'h0, "unmapped_rd"});
      tv.push_back('{1, 8'hC0, 32'hE, 4'h1, 0, ""});
      tv.push_back('{0, 8'hC0, 0, 0, 32'hE, "ctrl_rw"});
      tv.push_back('{1, 8'hC0, 32'h0, 4'h1, 0, ""});
      tv.push_back('{0, 8'hC0, 0, 0, 32'h0, "ctrl_clr"});

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {127'd0, ack}, 128'd0);
      chk("rst_start", {127'd0, st}, 128'd0);
      chk("rst_irq", {127'd0, irq}, 128'd0);
      chk("rst_key_bus", key, 128'd0);
      chk("rst_data_bus", cdo, 128'd0);
      chk("rst_dec", {127'd0, dec}, 128'd0);
      rst = 1'b0;

      foreach (tv[i]) begin
         bus(tv[i].w, tv[i].a, tv[i].d, tv[i].s, r, r2);
         if (!tv[i].w) chk(tv[i].nm, {96'd0, r}, {96'd0, tv[i].e});
      end
      chk("no_start_yet", 128'(start_cnt), 128'd0);

      // FIPS-197 AES-128 vector through the core model
      for (int i = 0; i < 4; i++) begin
         wr(8'h80 + 8'(4*i), KY[32*i +: 32]);
         wr(8'h00 + 8'(4*i), PT[32*i +: 32]);
      end
      chk("key_bus", key, KY);
      model_lat = 10;
      wr(8'hC0, 32'h1);
      chk("fips_start", {127'd0, st}, 128'd1);
      chk("fips_snap", cdo, PT);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         rd(8'h40 + 8'(4*i), r);
         chk($sformatf("fips_dout%0d", i), {96'd0, r},
             {96'd0, CT[32*i +: 32]});
      end
      rd(8'hC4, r);
      chk("fips_status", {96'd0, r}, 128'h2);
      bus(1'b0, 8'hC8, 32'h0, 4'h0, r, r2);
      chk("fips_cycles", {96'd0, r}, 128'd10);
      chk("fips_cycles_w4", {96'd0, r2}, 128'd10);
      wr(8'hC4, 32'h2);
      rd(8'hC4, r);
      chk("done_w1c", {96'd0, r}, 128'h0);

      // AUTO start on the last DIN word only
      wr(8'hC0, 32'h4);
      start_cnt = 0;
      wr(8'h00, PT[31:0]);
      repeat (4) @(posedge clk);
      #1;
      chk("auto_din0_nostart", 128'(start_cnt), 128'd0);
      wr(8'h04, PT[63:32]);
      wr(8'h08, PT[95:64]);
      wr(8'h0C, PT[127:96]);
      chk("auto_start", {127'd0, st}, 128'd1);
      @(posedge clk);
      #1;
      chk("auto_pulse_1cyc", {127'd0, st}, 128'd0);
      wait_idle();
      chk("auto_single", 128'(start_cnt), 128'd1);
      rd(8'h4C, r);
      chk("auto_dout3", {96'd0, r}, {96'd0, CT[127:96]});
      wr(8'h00, PT[31:0]);
      repeat (4) @(posedge clk);
      #1;
      chk("auto_din0_again", 128'(start_cnt), 128'd1);
      wr(8'hC0, 32'h0);
      wr(8'hC4, 32'h2);

      // Start while busy: ignored, flags ERR, mode snapshot held
      start_cnt = 0;
      wr(8'hC0, 32'h3);
      chk("coll_dec", {127'd0, dec}, 128'd1);
      wr(8'hC0, 32'h1);
      chk("coll_dec_held", {127'd0, dec}, 128'd1);
      rd(8'hC4, r);
      chk("coll_status", {96'd0, r}, 128'h5);
      wait_idle();
      chk("coll_single", 128'(start_cnt), 128'd1);
      rd(8'hC4, r);
      chk("coll_done_err", {96'd0, r}, 128'h6);
      wr(8'hC4, 32'h4);
      rd(8'hC4, r);
      chk("err_w1c", {96'd0, r}, 128'h2);
      wr(8'hC4, 32'h2);

      // DONE set in CAPT coincides with a DONE W1C: set wins
      model_en = 1'b0;
      wr(8'hC0, 32'h8);
      wr(8'hC0, 32'h9);
      repeat (3) @(posedge clk);
      #1;
      chk("irq_before_done", {127'd0, irq}, 128'd0);
      done_i = 1'b1;
      cdi = {4{32'h5A5A5A5A}};
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 8'hC4; dat_i = 32'h2; sel = 4'h1;
      @(posedge clk);
      #1;
      done_i = 1'b0;
      chk("race_ack", {127'd0, ack}, 128'd1);
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("race_irq", {127'd0, irq}, 128'd1);
      rd(8'hC4, r);
      chk("race_status", {96'd0, r}, 128'h2);
      wr(8'hC4, 32'h2);
      chk("irq_clr", {127'd0, irq}, 128'd0);
      wr(8'hC0, 32'h0);

      // Reset during RUN, then a stray done pulse in IDLE
      wr(8'hC0, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_data_bus", cdo, 128'd0);
      chk("mid_rst_key_bus", key, 128'd0);
      rst = 1'b0;
      done_i = 1'b1;
      cdi = '1;
      @(posedge clk);
      #1;
      done_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd(8'h40, r);
      chk("mid_rst_dout", {96'd0, r}, 128'h0);
      rd(8'hC4, r);
      chk("mid_rst_status", {96'd0, r}, 128'h0);
      model_en = 1'b1;

      // Counter saturation: 20-cycle core
      model_lat = 20;
      wr(8'hC0, 32'h1);
      wait_idle();
      bus(1'b0, 8'hC8, 32'h0, 4'h0, r, r2);
      chk("cycles_20", {96'd0, r}, 128'd20);
      chk("cycles_sat", {96'd0, r2}, 128'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aes_wb_ctrl.md
# aes_wb_ctrl

Parametrised Wishbone B3 slave front-end for the AES block-cipher core family. It holds the key, input-block and output-block register files, plus control and status registers. It sequences a single-outstanding start/done handshake to an attached cipher core, which may be 128/192/256-bit key, encrypt or decrypt. It replaces the fixed 128-bit plaintext/ciphertext register wrapper with a word-aligned map, a mode bit, auto-start, a sticky done flag, an interrupt and a latency counter.

## Interface
Parameters:
- BLOCK_WORDS, 4: 32-bit words per data block (cipher block size / 32).
- KEY_WORDS, 4: 32-bit key words; legal values 4, 6, 8.
- CNT_W, 16: width of the latency counter; saturates at all-ones.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_adr_i  in  8  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1.
- wb_sel_i  in  4  byte-lane enables for writes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  level interrupt = done & irq_en.
- core_start_o  out  1  one-cycle start pulse to core.
- core_decrypt_o  out  1  mode snapshot, held for the whole operation.
- core_key_o  out  32*KEY_WORDS  key; word 0 in bits [31:0].
- core_data_o  out  32*BLOCK_WORDS  input-block snapshot taken at start.
- core_done_i  in  1  one-cycle pulse; core_data_i valid in that cycle.
- core_data_i  in  32*BLOCK_WORDS  output block.

## Operation
Register map (word index i):
- DIN[i] @0x00+4i, RW, byte-laned.
- DOUT[i] @0x40+4i, RO.
- KEY[i] @0x80+4i, RW, byte-laned.
- CTRL @0xC0:
  - bit0 START (write-1 pulse, reads 0)
  - bit1 DECRYPT
  - bit2 AUTO (start on write to DIN[BLOCK_WORDS-1])
  - bit3 IRQ_EN
- STATUS @0xC4:
  - bit0 BUSY
  - bit1 DONE (sticky, write-1-to-clear)
  - bit2 ERR (sticky, W1C; start requested while busy)
- CYCLES @0xC8, RO: start-to-done latency of the last operation.
- Unmapped addresses read 0; writes to them are ignored, and they are still acked.

FSM states IDLE, RUN, CAPT:
- IDLE: a start request moves to RUN. Start requests are a CTRL write with wb_dat_i[0]=1 and wb_sel_i[0]=1, or an AUTO-triggered last-DIN write. On the request edge the FSM:
  - latches DIN into core_data_o and DECRYPT into core_decrypt_o;
  - asserts core_start_o for exactly one cycle;
  - clears the counter and sets BUSY.
- RUN: the counter increments every cycle, saturating. core_done_i moves to CAPT.
- CAPT: in one cycle, loads DOUT from the value captured at done, latches CYCLES, sets DONE and clears BUSY. Then returns to IDLE.

Rules:
- A start request in RUN or CAPT is ignored and sets ERR.
- DIN and KEY writes are always accepted. A DIN write during RUN affects only the next operation, because of the snapshot.
- KEY writes during RUN change core_key_o immediately. Software must not do this; it is not checked.
- If a DONE W1C and the setting of DONE coincide, the set wins. The same applies to ERR.
- Widths: core_key_o/core_data_o word j occupies bits [32j+31:32j]. DIN/KEY indices beyond BLOCK_WORDS/KEY_WORDS are unmapped.
- CYCLES is zero-extended to 32 bits on read.

## Timing
- Ack is registered: wb_ack_o = 1 in the cycle after cyc&stb with ack low, for one cycle. Every access therefore takes 2 cycles, and back-to-back strobes are acked every other cycle.
- A write takes effect on the ack edge. Read data is registered with the ack.
- Start latency: core_start_o is high in the cycle after the ack of the triggering write. BUSY reads 1 from then on.
- DOUT, DONE and CYCLES are visible 1 cycle after core_done_i. With a core done-latency of N cycles after start, CYCLES reads N.
- Reset (synchronous): all registers and the counter are 0, FSM is IDLE, and every output is 0. This includes wb_ack_o, irq_o, core_start_o and core_* buses. Reset mid-RUN abandons the operation; a later core_done_i in IDLE is ignored.
- irq_o is combinational from the DONE and IRQ_EN flops, so it has no extra latency.

## Test plan
- Reset defaults: after reset, read all registers → 0. Write CTRL with sel=4'h0 → no effect, ack still returned.
- FIPS-197 vector with a core model (done 10 cycles after start):
  - stimulus: KEY=000102..0f, DIN=00112233..ccddeeff, START;
  - required: DOUT=69c4e0d8..70b4c55a, DONE=1, CYCLES=10, BUSY=0.
- AUTO mode: CTRL=0x4, then write DIN[0..3] → core_start_o pulses exactly once, the cycle after the DIN[3] ack. Writing DIN[0] alone → no start.
- Busy collision: START, then START again during RUN → single core_start_o, ERR=1. Then W1C STATUS=0x4 → ERR=0.
- IRQ and W1C race: IRQ_EN=1 and DONE W1C issued in the same cycle as the CAPT set → DONE stays 1, irq_o=1. A subsequent W1C → irq_o=0.
- Reset mid-RUN and saturation: assert reset during RUN, then a core done pulse → DOUT stays 0 and DONE=0. With CNT_W=4 and a 20-cycle core → CYCLES=15.
